id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32: width of PC, register-operand and immediate paths.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 id_valid  input  1  ID slot holds a real instruction.
REQ-005 id_ctrl  input  17  decoded control word, MSB→LSB: {RegWrite, RegDst[1:0], MemRead, MemWrite, MemtoReg[1:0], ALUSrc1, ALUSrc2, ALUOp[3:0], LbOp, BranchType[2:0]}.
REQ-006 id_pc4  input  DATA_W  PC+4 of the ID instruction.
REQ-007 id_rs_data, id_rt_data  input  DATA_W each  register-file read values.
REQ-008 id_imm  input  DATA_W  extended (or LUI-shifted) immediate.
REQ-009 id_instr  input  32  raw instruction; rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0].
REQ-010 ex_flush  input  1  branch/jump resolved taken downstream; ID instruction is wrong-path.
REQ-011 ex_valid, ex_ctrl, ex_pc4, ex_rs_data, ex_rt_data, ex_imm  output  1/17/DATA_W×4  registered copies of the ID inputs.
REQ-012 ex_rs, ex_rt, ex_rd, ex_shamt  output  5 each  registered instruction fields.
REQ-013 ex_funct  output  6  registered funct field.
REQ-014 stall  output  1  combinational; holds PC and IF/ID register this cycle.
REQ-015 bubble_cnt  output  16  registered count of bubbles inserted by load-use stalls.

Function
REQ-016 Latency: exactly one cycle from ID inputs to ex_* outputs; no combinational path from id_* to ex_*.
REQ-017 Load-use hazard: hz = ex_valid & ex_ctrl.MemRead & (ex_rt≠0) & ((ex_rt==id_instr[25:21]) | (ex_rt==id_instr[20:16])) & id_valid.
REQ-018 stall SHALL equal hz & ~ex_flush & ~reset.
REQ-019 Each edge selects exactly one action, priority reset > flush > stall > load.
REQ-020 Load: capture all id_* into ex_*; ex_valid ← id_valid.
REQ-021 Flush: ex_valid ← 0, ex_ctrl ← 0; data/field registers don't-care, held.
REQ-022 Stall: insert bubble; ex_valid ← 0, ex_ctrl ← 0; bubble_cnt increments.
REQ-023 A bubble SHALL never assert RegWrite, MemRead or MemWrite, nor a nonzero BranchType.
REQ-024 Load with id_valid=0: ex_ctrl ← 0 irrespective of id_ctrl.
REQ-025 A stall lasts at most one cycle per load; after the bubble ex_valid=0, so hz deasserts next cycle.
REQ-026 bubble_cnt saturates at 16'hFFFF; flush bubbles are not counted.
REQ-027 Flush concurrent with hazard: flush wins; no stall, bubble_cnt unchanged.
REQ-028 ex_rt==0 (load into $zero) never causes a stall.

Reset
REQ-029 On clk edge with reset=1: ex_valid=0, ex_ctrl=0, all data/field outputs=0, bubble_cnt=0; stall=0 while reset high.
REQ-030 Reset mid-stall: the stall is abandoned; first post-reset edge performs a normal load.

Verification
REQ-031 lw $t0(rt=8) in EX, ID add rs=8 -> stall=1 one cycle, next ex_ctrl=0, ex_valid=0, bubble_cnt=1; following cycle add loads.
REQ-032 lw rt=8 in EX, ID rt=8 (sw data) -> stall=1; ID rs=9, rt=10 -> stall=0, direct load.
REQ-033 lw rt=0 in EX, ID rs=0 -> stall=0.
REQ-034 Hazard and ex_flush=1 same cycle -> stall=0, ex_valid=0, ex_ctrl=0, bubble_cnt unchanged.
REQ-035 ID addi (id_ctrl=17'h1_0348 example), id_pc4=32'h0040_0004 -> next cycle identical ex_ctrl, ex_pc4=32'h0040_0004, ex_valid=1.
REQ-036 bubble_cnt preset to 16'hFFFF by forced stalls, one more stall -> stays 16'hFFFF; reset=1 one edge -> all outputs 0.

Source files
------------

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// Purpose:
//   ID/EX pipeline register for a classic five-stage MIPS-style pipeline.
//   The module carries the decoded ID instruction into EX one cycle later.
//   It also detects a load-use hazard between the load now in EX and the
//   instruction now in ID. On a hazard it stalls the front end for one cycle
//   and inserts a bubble. A taken branch or jump resolved downstream flushes
//   the wrong-path ID instruction.
//
// Ports:
//   clk          in   sole clock, rising edge
//   reset        in   synchronous, active-high reset
//   id_valid     in   ID slot holds a real instruction
//   id_ctrl      in   17-bit decoded control word
//                     {RegWrite, RegDst[1:0], MemRead, MemWrite,
//                      MemtoReg[1:0], ALUSrc1, ALUSrc2, ALUOp[3:0],
//                      LbOp, BranchType[2:0]}
//   id_pc4       in   PC+4 of the ID instruction
//   id_rs_data   in   register-file read value for rs
//   id_rt_data   in   register-file read value for rt
//   id_imm       in   extended (or LUI-shifted) immediate
//   id_instr     in   raw 32-bit instruction word
//   ex_flush     in   downstream redirect; the ID instruction is wrong-path
//   ex_valid     out  registered valid
//   ex_ctrl      out  registered control word (all zero for a bubble)
//   ex_pc4       out  registered PC+4
//   ex_rs_data   out  registered rs value
//   ex_rt_data   out  registered rt value
//   ex_imm       out  registered immediate
//   ex_rs/rt/rd  out  registered register-number fields
//   ex_shamt     out  registered shift amount
//   ex_funct     out  registered funct field
//   stall        out  combinational; holds PC and IF/ID this cycle
//   bubble_cnt   out  saturating count of load-use bubbles
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              id_valid,
  input  logic [16:0]       id_ctrl,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [31:0]       id_instr,
  input  logic              ex_flush,

  output logic              ex_valid,
  output logic [16:0]       ex_ctrl,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [4:0]        ex_shamt,
  output logic [5:0]        ex_funct,

  output logic              stall,
  output logic [15:0]       bubble_cnt
);

  // Bit position of MemRead inside the control word.
  localparam int MEMREAD_BIT = 13;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // One action per edge, chosen in strict priority order.
  typedef enum logic [1:0] {
    ACT_RESET,
    ACT_FLUSH,
    ACT_STALL,
    ACT_LOAD
  } action_e;

  action_e action;

  // Pipeline state
  logic              valid_q,    valid_d;
  logic [16:0]       ctrl_q,     ctrl_d;
  logic [DATA_W-1:0] pc4_q,      pc4_d;
  logic [DATA_W-1:0] rs_data_q,  rs_data_d;
  logic [DATA_W-1:0] rt_data_q,  rt_data_d;
  logic [DATA_W-1:0] imm_q,      imm_d;
  logic [4:0]        rs_q,       rs_d;
  logic [4:0]        rt_q,       rt_d;
  logic [4:0]        rd_q,       rd_d;
  logic [4:0]        shamt_q,    shamt_d;
  logic [5:0]        funct_q,    funct_d;
  logic [15:0]       bubble_cnt_q, bubble_cnt_d;

  // Instruction fields of the ID instruction
  logic [4:0] idRs;
  logic [4:0] idRt;
  logic [4:0] idRd;
  logic [4:0] idShamt;
  logic [5:0] idFunct;

  assign idRs    = id_instr[25:21];
  assign idRt    = id_instr[20:16];
  assign idRd    = id_instr[15:11];
  assign idShamt = id_instr[10:6];
  assign idFunct = id_instr[5:0];

  // Load-use hazard. A load into $zero never produces a usable value, so it
  // can never be a dependency. Both source fields are compared even for
  // instructions that do not read rt; stalling one extra cycle there is
  // harmless, and it keeps the check independent of the opcode decoder.
  logic exIsLoad;
  logic rtIsNonzero;
  logic srcMatch;
  logic hazard;

  assign exIsLoad    = valid_q & ctrl_q[MEMREAD_BIT];
  assign rtIsNonzero = (rt_q != 5'd0);
  assign srcMatch    = (rt_q == idRs) | (rt_q == idRt);
  assign hazard      = exIsLoad & rtIsNonzero & srcMatch & id_valid;

  // A flush makes the ID instruction wrong-path, so stalling for it would
  // only waste a cycle. Reset also masks the stall so the front end is free
  // while the pipe is being cleared.
  assign stall = hazard & ~ex_flush & ~reset;

  // Action select: reset > flush > stall > load.
  always_comb begin
    action = ACT_LOAD;
    if (reset) begin
      action = ACT_RESET;
    end else if (ex_flush) begin
      action = ACT_FLUSH;
    end else if (stall) begin
      action = ACT_STALL;
    end
  end

  // Next-state logic. Flush and stall both produce a bubble with an all-zero
  // control word, so RegWrite, MemRead, MemWrite and BranchType are all
  // inactive. The data and field registers simply hold. Only load-use
  // bubbles are counted, and the counter sticks at its maximum.
  always_comb begin
    valid_d      = valid_q;
    ctrl_d       = ctrl_q;
    pc4_d        = pc4_q;
    rs_data_d    = rs_data_q;
    rt_data_d    = rt_data_q;
    imm_d        = imm_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    rd_d         = rd_q;
    shamt_d      = shamt_q;
    funct_d      = funct_q;
    bubble_cnt_d = bubble_cnt_q;

    case (action)
      ACT_RESET: begin
        valid_d      = 1'b0;
        ctrl_d       = '0;
        pc4_d        = '0;
        rs_data_d    = '0;
        rt_data_d    = '0;
        imm_d        = '0;
        rs_d         = '0;
        rt_d         = '0;
        rd_d         = '0;
        shamt_d      = '0;
        funct_d      = '0;
        bubble_cnt_d = '0;
      end

      ACT_FLUSH: begin
        valid_d = 1'b0;
        ctrl_d  = '0;
      end

      ACT_STALL: begin
        valid_d = 1'b0;
        ctrl_d  = '0;
        if (bubble_cnt_q != CNT_MAX) begin
          bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
      end

      default: begin
        // An invalid ID slot must not carry live control into EX.
        valid_d   = id_valid;
        ctrl_d    = id_valid ? id_ctrl : '0;
        pc4_d     = id_pc4;
        rs_data_d = id_rs_data;
        rt_data_d = id_rt_data;
        imm_d     = id_imm;
        rs_d      = idRs;
        rt_d      = idRt;
        rd_d      = idRd;
        shamt_d   = idShamt;
        funct_d   = idFunct;
      end
    endcase
  end

  // All state updates on the rising edge. Reset is handled synchronously
  // through the ACT_RESET branch above.
  always_ff @(posedge clk) begin
    valid_q      <= valid_d;
    ctrl_q       <= ctrl_d;
    pc4_q        <= pc4_d;
    rs_data_q    <= rs_data_d;
    rt_data_q    <= rt_data_d;
    imm_q        <= imm_d;
    rs_q         <= rs_d;
    rt_q         <= rt_d;
    rd_q         <= rd_d;
    shamt_q      <= shamt_d;
    funct_q      <= funct_d;
    bubble_cnt_q <= bubble_cnt_d;
  end

  assign ex_valid   = valid_q;
  assign ex_ctrl    = ctrl_q;
  assign ex_pc4     = pc4_q;
  assign ex_rs_data = rs_data_q;
  assign ex_rt_data = rt_data_q;
  assign ex_imm     = imm_q;
  assign ex_rs      = rs_q;
  assign ex_rt      = rt_q;
  assign ex_rd      = rd_q;
  assign ex_shamt   = shamt_q;
  assign ex_funct   = funct_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//
// Directed testbench for id_ex_stage. Inputs change on the falling edge.
// The combinational stall output is sampled shortly after the inputs
// change, and the registered outputs are sampled on the falling edge after
// each rising edge.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam int DATA_W = 32;

  // Control words used as stimulus
  localparam logic [16:0] CTRL_ADDI = 17'h1_0348;
  localparam logic [16:0] CTRL_LW   = 17'h1_2500;
  localparam logic [16:0] CTRL_ADD  = 17'h1_4020;
  localparam logic [16:0] CTRL_SW   = 17'h0_1100;
  localparam logic [16:0] CTRL_ALL  = 17'h1_FFFF;

  logic              clk;
  logic              reset;
  logic              idValid;
  logic [16:0]       idCtrl;
  logic [DATA_W-1:0] idPc4;
  logic [DATA_W-1:0] idRsData;
  logic [DATA_W-1:0] idRtData;
  logic [DATA_W-1:0] idImm;
  logic [31:0]       idInstr;
  logic              exFlush;

  logic              exValid;
  logic [16:0]       exCtrl;
  logic [DATA_W-1:0] exPc4;
  logic [DATA_W-1:0] exRsData;
  logic [DATA_W-1:0] exRtData;
  logic [DATA_W-1:0] exImm;
  logic [4:0]        exRs;
  logic [4:0]        exRt;
  logic [4:0]        exRd;
  logic [4:0]        exShamt;
  logic [5:0]        exFunct;
  logic              stall;
  logic [15:0]       bubbleCnt;

  int checkCount;
  int errorCount;

  id_ex_stage #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .id_valid   (idValid),
    .id_ctrl    (idCtrl),
    .id_pc4     (idPc4),
    .id_rs_data (idRsData),
    .id_rt_data (idRtData),
    .id_imm     (idImm),
    .id_instr   (idInstr),
    .ex_flush   (exFlush),
    .ex_valid   (exValid),
    .ex_ctrl    (exCtrl),
    .ex_pc4     (exPc4),
    .ex_rs_data (exRsData),
    .ex_rt_data (exRtData),
    .ex_imm     (exImm),
    .ex_rs      (exRs),
    .ex_rt      (exRt),
    .ex_rd      (exRd),
    .ex_shamt   (exShamt),
    .ex_funct   (exFunct),
    .stall      (stall),
    .bubble_cnt (bubbleCnt)
  );

  // 10 time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // R-type style instruction word from register fields
  function automatic logic [31:0] mkInstr(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] shamt,
                                          input logic [5:0] funct);
    return {6'd0, rs, rt, rd, shamt, funct};
  endfunction

  // Drive the ID slot, then let the stall output settle.
  task automatic applyStimulus(input logic valid, input logic [16:0] ctrl,
                               input logic [31:0] pc4, input logic [31:0] instr,
                               input logic [31:0] rsData, input logic [31:0] rtData,
                               input logic [31:0] imm);
    idValid  = valid;
    idCtrl   = ctrl;
    idPc4    = pc4;
    idInstr  = instr;
    idRsData = rsData;
    idRtData = rtData;
    idImm    = imm;
    #1;
  endtask

  // Advance one rising edge; return on the following falling edge.
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".valid"},  64'(exValid),   64'd0);
    checkOutput({tag, ".ctrl"},   64'(exCtrl),    64'd0);
    checkOutput({tag, ".pc4"},    64'(exPc4),     64'd0);
    checkOutput({tag, ".rsData"}, 64'(exRsData),  64'd0);
    checkOutput({tag, ".rtData"}, 64'(exRtData),  64'd0);
    checkOutput({tag, ".imm"},    64'(exImm),     64'd0);
    checkOutput({tag, ".rs"},     64'(exRs),      64'd0);
    checkOutput({tag, ".rt"},     64'(exRt),      64'd0);
    checkOutput({tag, ".rd"},     64'(exRd),      64'd0);
    checkOutput({tag, ".shamt"},  64'(exShamt),   64'd0);
    checkOutput({tag, ".funct"},  64'(exFunct),   64'd0);
    checkOutput({tag, ".bubble"}, 64'(bubbleCnt), 64'd0);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    exFlush    = 1'b0;
    reset      = 1'b1;

    // Reset, with a busy ID slot that must not leak through
    @(negedge clk);
    applyStimulus(1'b1, CTRL_ALL, 32'hDEAD_BEEF, mkInstr(5'd3, 5'd4, 5'd5, 5'd6, 6'h21),
                  32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
    checkOutput("resetStall", 64'(stall), 64'd0);
    tick();
    checkAllZero("reset");

    // addi $10, $9, imm: plain one-cycle load
    reset = 1'b0;
    applyStimulus(1'b1, CTRL_ADDI, 32'h0040_0004, {6'h08, 5'd9, 5'd10, 16'h0042},
                  32'h0000_00A5, 32'h0000_005A, 32'h0000_0042);
    checkOutput("addiStall", 64'(stall), 64'd0);
    tick();
    checkOutput("addi.valid",  64'(exValid),  64'd1);
    checkOutput("addi.ctrl",   64'(exCtrl),   64'(CTRL_ADDI));
    checkOutput("addi.pc4",    64'(exPc4),    64'h0040_0004);
    checkOutput("addi.rsData", 64'(exRsData), 64'h0000_00A5);
    checkOutput("addi.rtData", 64'(exRtData), 64'h0000_005A);
    checkOutput("addi.imm",    64'(exImm),    64'h0000_0042);
    checkOutput("addi.rs",     64'(exRs),     64'd9);
    checkOutput("addi.rt",     64'(exRt),     64'd10);
    checkOutput("addi.rd",     64'(exRd),     64'd0);
    checkOutput("addi.shamt",  64'(exShamt),  64'd1);
    checkOutput("addi.funct",  64'(exFunct),  64'h02);

    // lw $8: no hazard against the addi in EX
    applyStimulus(1'b1, CTRL_LW, 32'h0040_0008, mkInstr(5'd29, 5'd8, 5'd0, 5'd0, 6'd0),
                  32'h0, 32'h0, 32'h10);
    checkOutput("lwNoStall", 64'(stall), 64'd0);
    tick();
    checkOutput("lw.ctrl", 64'(exCtrl), 64'(CTRL_LW));
    checkOutput("lw.rt",   64'(exRt),   64'd8);

    // add $10, $8, $9 depends on the load through rs
    applyStimulus(1'b1, CTRL_ADD, 32'h0040_000C, mkInstr(5'd8, 5'd9, 5'd10, 5'd0, 6'h20),
                  32'h5, 32'h6, 32'h0);
    checkOutput("useRsStall", 64'(stall), 64'd1);
    tick();
    checkOutput("bubble1.valid", 64'(exValid),   64'd0);
    checkOutput("bubble1.ctrl",  64'(exCtrl),    64'd0);
    checkOutput("bubble1.cnt",   64'(bubbleCnt), 64'd1);
    checkOutput("afterBubbleStall", 64'(stall), 64'd0);
    tick();
    checkOutput("addLoad.valid", 64'(exValid),   64'd1);
    checkOutput("addLoad.ctrl",  64'(exCtrl),    64'(CTRL_ADD));
    checkOutput("addLoad.rd",    64'(exRd),      64'd10);
    checkOutput("addLoad.pc4",   64'(exPc4),     64'h0040_000C);
    checkOutput("addLoad.cnt",   64'(bubbleCnt), 64'd1);

    // lw $8, then sw $8: dependency through rt
    applyStimulus(1'b1, CTRL_LW, 32'h0040_0010, mkInstr(5'd29, 5'd8, 5'd0, 5'd0, 6'd0),
                  32'h0, 32'h0, 32'h4);
    tick();
    applyStimulus(1'b1, CTRL_SW, 32'h0040_0014, mkInstr(5'd29, 5'd8, 5'd0, 5'd0, 6'd0),
                  32'h0, 32'h0, 32'h8);
    checkOutput("useRtStall", 64'(stall), 64'd1);
    tick();
    checkOutput("bubble2.cnt", 64'(bubbleCnt), 64'd2);

    // lw $8, then an instruction reading $9/$10 only: no stall
    applyStimulus(1'b1, CTRL_LW, 32'h0040_0018, mkInstr(5'd29, 5'd8, 5'd0, 5'd0, 6'd0),
                  32'h0, 32'h0, 32'h4);
    tick();
    applyStimulus(1'b1, CTRL_ADD, 32'h0040_001C, mkInstr(5'd9, 5'd10, 5'd11, 5'd0, 6'h20),
                  32'h0, 32'h0, 32'h0);
    checkOutput("indepStall", 64'(stall), 64'd0);
    tick();
    checkOutput("indep.valid", 64'(exValid), 64'd1);
    checkOutput("indep.rd",    64'(exRd),    64'd11);

    // Load into $zero never stalls
    applyStimulus(1'b1, CTRL_LW, 32'h0040_0020, mkInstr(5'd4, 5'd0, 5'd0, 5'd0, 6'd0),
                  32'h0, 32'h0, 32'h0);
    tick();
    applyStimulus(1'b1, CTRL_ADD, 32'h0040_0024, mkInstr(5'd0, 5'd0, 5'd12, 5'd0, 6'h20),
                  32'h0, 32'h0, 32'h0);
    checkOutput("zeroRtStall", 64'(stall), 64'd0);
    tick();
    checkOutput("zeroRt.valid", 64'(exValid), 64'd1);

    // Hazard and flush together: flush wins, counter untouched
    applyStimulus(1'b1, CTRL_LW, 32'h0040_0028, mkInstr(5'd29, 5'd8, 5'd0, 5'd0, 6'd0),
                  32'h0, 32'h0, 32'h4);
    tick();
    exFlush = 1'b1;
    applyStimulus(1'b1, CTRL_ADD, 32'h0040_002C, mkInstr(5'd8, 5'd9, 5'd10, 5'd0, 6'h20),
                  32'h0, 32'h0, 32'h0);
    checkOutput("flushStall", 64'(stall), 64'd0);
    tick();
    exFlush = 1'b0;
    checkOutput("flush.valid", 64'(exValid),   64'd0);
    checkOutput("flush.ctrl",  64'(exCtrl),    64'd0);
    checkOutput("flush.cnt",   64'(bubbleCnt), 64'd2);

    // Invalid ID slot loads a zero control word
    applyStimulus(1'b0, CTRL_ALL, 32'h0040_0030, mkInstr(5'd1, 5'd2, 5'd3, 5'd4, 6'h05),
                  32'h0, 32'h0, 32'h0);
    tick();
    checkOutput("invalid.valid", 64'(exValid), 64'd0);
    checkOutput("invalid.ctrl",  64'(exCtrl),  64'd0);
    checkOutput("invalid.pc4",   64'(exPc4),   64'h0040_0030);

    // Reset in the middle of a stall abandons it
    applyStimulus(1'b1, CTRL_LW, 32'h0040_0034, mkInstr(5'd29, 5'd8, 5'd0, 5'd0, 6'd0),
                  32'h0, 32'h0, 32'h4);
    tick();
    applyStimulus(1'b1, CTRL_ADD, 32'h0040_0038, mkInstr(5'd8, 5'd9, 5'd10, 5'd0, 6'h20),
                  32'h7, 32'h8, 32'h0);
    checkOutput("preResetStall", 64'(stall), 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("midResetStall", 64'(stall), 64'd0);
    tick();
    checkAllZero("midReset");
    reset = 1'b0;
    #1;
    checkOutput("postResetStall", 64'(stall), 64'd0);
    tick();
    checkOutput("postReset.valid", 64'(exValid), 64'd1);
    checkOutput("postReset.ctrl",  64'(exCtrl),  64'(CTRL_ADD));
    checkOutput("postReset.pc4",   64'(exPc4),   64'h0040_0038);

    // Saturation: preset the counter one below the top, then stall twice
    applyStimulus(1'b1, CTRL_LW, 32'h0040_003C, mkInstr(5'd29, 5'd8, 5'd0, 5'd0, 6'd0),
                  32'h0, 32'h0, 32'h4);
    tick();
    force dut.bubble_cnt_q = 16'hFFFE;
    #1;
    release dut.bubble_cnt_q;
    #1;
    checkOutput("preset.cnt", 64'(bubbleCnt), 64'hFFFE);
    applyStimulus(1'b1, CTRL_ADD, 32'h0040_0040, mkInstr(5'd8, 5'd9, 5'd10, 5'd0, 6'h20),
                  32'h0, 32'h0, 32'h0);
    checkOutput("satStallA", 64'(stall), 64'd1);
    tick();
    checkOutput("satA.cnt", 64'(bubbleCnt), 64'hFFFF);
    applyStimulus(1'b1, CTRL_LW, 32'h0040_0044, mkInstr(5'd29, 5'd8, 5'd0, 5'd0, 6'd0),
                  32'h0, 32'h0, 32'h4);
    tick();
    applyStimulus(1'b1, CTRL_ADD, 32'h0040_0048, mkInstr(5'd8, 5'd9, 5'd10, 5'd0, 6'h20),
                  32'h0, 32'h0, 32'h0);
    checkOutput("satStallB", 64'(stall), 64'd1);
    tick();
    checkOutput("satB.cnt",   64'(bubbleCnt), 64'hFFFF);
    checkOutput("satB.valid", 64'(exValid),   64'd0);

    // A single reset edge clears everything, including the saturated counter
    reset = 1'b1;
    #1;
    tick();
    checkAllZero("finalReset");
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1, "[TB] timeout");
  end

endmodule
